// File: rtl/pipe_adder_pkg.sv
// Shared constants and operation encoding for the chunked pipelined adder.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/pipe_adder_chunk_adder.sv
// CW-bit ripple-carry adder used for one chunk of the pipelined adder.
module chunk_adder
    import pipe_adder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic [CW:0] cv;

    always_comb begin
        cv    = '0;
        sum   = '0;
        cv[0] = cin;
        for (int i = 0; i < CW; i++) begin
            sum[i]  = a[i] ^ b[i] ^ cv[i];
            cv[i+1] = (a[i] & b[i]) | (cv[i] & (a[i] ^ b[i]));
        end
        cout = cv[CW];
        cmsb = cv[CW-1];
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one CW-bit chunk per stage, valid/ready
// handshake with per-stage valid bits and full back-pressure.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [STAGES-1:0] go, load;
    logic [STAGES-1:0] src_v, src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [CW-1:0]     ch_sum [STAGES];
    logic [STAGES-1:0] ch_cout;
    logic              ch_cmsb [STAGES];
    op_e               op;

    assign op = op_e'(sub);

    // Stage 0 is fed from the ports; later stages from their predecessor.
    always_comb begin
        src_v    = '0;
        src_c    = '0;
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = (op == OP_SUB) ? ~b : b;
        src_c[0] = (op == OP_SUB) ? 1'b1 : carry_in;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = valid_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_c[k] = c_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    // A stage moves on if any later stage has a hole or the sink takes data.
    always_comb begin
        go = '0;
        for (int k = 0; k < STAGES; k++) begin
            go[k] = out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    go[k] = 1'b1;
                end
            end
        end
    end

    assign load = ~valid_q | go;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(.CW(CW)) u_add (
            .a    (src_a[k][k*CW +: CW]),
            .b    (src_b[k][k*CW +: CW]),
            .cin  (src_c[k]),
            .sum  (ch_sum[k]),
            .cout (ch_cout[k]),
            .cmsb (ch_cmsb[k])
        );
    end

    always_comb begin
        valid_d = valid_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = src_v[k];
                if (src_v[k]) begin
                    a_d[k]              = src_a[k];
                    b_d[k]              = src_b[k];
                    s_d[k]              = src_s[k];
                    s_d[k][k*CW +: CW]  = ch_sum[k];
                    c_d[k]              = ch_cout[k];
                end
            end
        end
        if (load[LAST] && src_v[LAST]) begin
            ovf_d  = ch_cmsb[LAST] ^ ch_cout[LAST];
            zero_d = (s_d[LAST] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign in_ready  = ~reset & load[0];
    assign out_valid = valid_q[LAST];
    assign sum       = s_q[LAST];
    assign carry_out = c_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder with an arithmetic scoreboard model.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        cin_i = 1'b0;
    logic        sub_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .carry_in  (cin_i),
        .sub       (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          acc;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   n_out = 0;
    bit   post_rst = 1'b0;

    function automatic ent_t model(logic [31:0] a, logic [31:0] b,
                                   logic cin, logic sb);
        ent_t        r;
        logic [31:0] eb;
        logic [32:0] f;
        eb    = sb ? ~b : b;
        f     = {1'b0, a} + {1'b0, eb} + {32'd0, (sb ? 1'b1 : cin)};
        r.s   = f[31:0];
        r.c   = f[32];
        r.v   = (a[31] == eb[31]) && (r.s[31] != a[31]);
        r.z   = (r.s == 32'd0);
        r.acc = 0;
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    // Monitor: samples 2 time units before each rising edge.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (reset) begin
                chk("rst_in_ready", in_ready, 0);
                q.delete();
                post_rst = 1'b1;
            end else begin
                if (post_rst) begin
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_sum", sum, 0);
                    chk("rst_carry", carry_out, 0);
                    chk("rst_ovf", overflow, 0);
                    chk("rst_zero", zero, 0);
                    chk("rst_in_ready_after", in_ready, 1);
                    post_rst = 1'b0;
                end
                chk("in_ready", in_ready, (q.size() < 4) || out_ready);
                chk("out_valid", out_valid,
                    (q.size() > 0) && (cyc - q[0].acc >= 4));
                if (out_valid && q.size() > 0) begin
                    chk("sum", sum, q[0].s);
                    chk("carry_out", carry_out, q[0].c);
                    chk("overflow", overflow, q[0].v);
                    chk("zero", zero, q[0].z);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
                if (in_valid && in_ready) begin
                    e     = model(a_i, b_i, cin_i, sub_i);
                    e.acc = cyc;
                    q.push_back(e);
                    n_in++;
                end
            end
        end
    end

    task automatic send(logic [31:0] a, logic [31:0] b, logic c, logic s);
        bit ok;
        int w;
        ok = 1'b0;
        w  = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        a_i      = a;
        b_i      = b;
        cin_i    = c;
        sub_i    = s;
        do begin
            #2;
            ok = in_ready;
            @(posedge clk);
            if (!ok) begin
                @(negedge clk);
                #1;
            end
            w++;
        end while (!ok && w < 50);
        chk("send_accept", ok, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        ent_t m;
        int   b_in;
        int   b_out;

        m = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("pin_wrap_sum", m.s, 32'h0);
        chk("pin_wrap_c", m.c, 1);
        chk("pin_wrap_z", m.z, 1);
        chk("pin_wrap_v", m.v, 0);
        m = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("pin_ovf_sum", m.s, 32'h8000_0000);
        chk("pin_ovf_v", m.v, 1);
        chk("pin_ovf_c", m.c, 0);
        m = model(32'h00FF_FFFF, 32'h0, 1'b1, 1'b0);
        chk("pin_cin_sum", m.s, 32'h0100_0000);
        m = model(32'd5, 32'd7, 1'b0, 1'b1);
        chk("pin_sub_sum", m.s, 32'hFFFF_FFFE);
        chk("pin_sub_c", m.c, 0);
        chk("pin_sub_v", m.v, 0);
        m = model(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        chk("pin_subov_sum", m.s, 32'h7FFF_FFFF);
        chk("pin_subov_v", m.v, 1);

        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;

        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        idle();
        drain();
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        idle();
        drain();

        send(32'h00FF_FFFF, 32'h0, 1'b1, 1'b0);
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        send(32'd10, 32'd3, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h0000_FF00, 32'h0000_0100, 1'b0, 1'b0);
        idle();
        drain();

        b_in  = n_in;
        b_out = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(32'h1000 * (i + 1), 32'hFF + i, i[0], i[1]);
                end
                idle();
            end
            begin
                @(negedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                chk("stall_accepted", n_in - b_in, 4);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_all_in", n_in - b_in, 6);
        chk("stall_all_out", n_out - b_out, 6);

        b_out = n_out;
        send(32'h1, 32'h2, 1'b0, 1'b0);
        send(32'h3, 32'h4, 1'b0, 1'b0);
        send(32'h5, 32'h6, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_no_stale", n_out - b_out, 0);

        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
        idle();
        drain();
        chk("final_out", n_out - b_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: STAGES, 4, pipeline stage count; WIDTH SHALL be an integer multiple of STAGES; chunk width CW = WIDTH/STAGES.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand set presented.
REQ-006 Port: in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: carry_in  input  1  carry into bit 0 (add mode only).
REQ-010 Port: sub  input  1  0 = A+B+carry_in, 1 = A-B.
REQ-011 Port: out_valid  output  1  result present.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: sum  output  WIDTH  result.
REQ-014 Port: carry_out  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 Port: overflow  output  1  two's-complement signed overflow.
REQ-016 Port: zero  output  1  sum == 0.

Function
REQ-017 Transfer SHALL occur on input when in_valid & in_ready, on output when out_valid & out_ready, at the clock edge.
REQ-018 Effective B SHALL be ~b and effective carry-in SHALL be 1 when sub=1; carry_in SHALL be ignored when sub=1.
REQ-019 Stage k (0..STAGES-1) SHALL add chunk k (bits k*CW+CW-1 : k*CW) using the carry registered from stage k-1 (stage 0 uses effective carry-in).
REQ-020 Operand chunks not yet consumed SHALL travel with their transaction; completed sum chunks SHALL be registered alongside.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when out_ready stays high.
REQ-022 Throughput SHALL be one transaction per cycle when out_ready stays high.
REQ-023 Each stage holds a valid bit; stage k SHALL advance when stage k+1 is empty or advancing (last stage: out_ready); in_ready = ~valid[0] | advance[0].
REQ-024 A stalled stage SHALL hold all its data unchanged; no transaction SHALL be dropped, duplicated or reordered.
REQ-025 When all STAGES valid bits are set and out_ready=0, in_ready SHALL be 0.
REQ-026 Simultaneous output transfer and input transfer on a full pipeline SHALL both succeed in the same cycle.
REQ-027 overflow SHALL equal carry into MSB XOR carry_out; zero SHALL be derived from the full final sum.
REQ-028 sum, carry_out, overflow, zero SHALL be registered outputs of the last stage and valid only while out_valid=1.

Reset
REQ-029 While reset=1, all stage valid bits SHALL clear on the next edge; out_valid=0, sum=0, carry_out=0, overflow=0, zero=0.
REQ-030 in_ready SHALL be 0 while reset=1 and 1 on the first cycle after reset deasserts.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear at the output afterward.

Structure
REQ-032 Shared package SHALL hold default WIDTH/STAGES constants and the op-mode encoding (ADD=0, SUB=1).
REQ-033 One sub-module SHALL be used: chunk_adder, a CW-bit ripple adder (a, b, cin -> sum, cout, carry into MSB) instantiated once per stage.

Verification (WIDTH=32, STAGES=4)
REQ-034 Add 0xFFFFFFFF + 0x00000001, carry_in=0 -> sum 0x00000000, carry_out 1, zero 1, overflow 0, out_valid exactly 4 cycles after acceptance.
REQ-035 Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, overflow 1, carry_out 0; add 0x00FFFFFF + 0x00000000, carry_in=1 -> 0x01000000 (carry crosses chunks).
REQ-036 Sub 5 - 7 -> sum 0xFFFFFFFE, carry_out 0, overflow 0; sub 0x80000000 - 1 -> 0x7FFFFFFF, overflow 1.
REQ-037 Issue 6 back-to-back ops with out_ready=0 for 5 cycles -> in_ready drops after 4 accepted, all 6 results emerge in order, none lost.
REQ-038 Assert reset for 1 cycle with 3 ops in flight -> out_valid 0 next cycle, no stale result ever emitted, in_ready 1 the following cycle.
